// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan decoder:
//   - SEG7_0 .. SEG7_F : active-low glyph patterns, bit order {g,f,e,d,c,b,a}
//   - NUM_DIGITS_MAX   : largest supported digit count
//   - scan_state_e     : strobe-qualification FSM states
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS_MAX = 8;

  // Active-low glyphs: a 0 bit lights the segment.
  localparam logic [6:0] SEG7_0 = 7'b1000000;
  localparam logic [6:0] SEG7_1 = 7'b1111001;
  localparam logic [6:0] SEG7_2 = 7'b0100100;
  localparam logic [6:0] SEG7_3 = 7'b0110000;
  localparam logic [6:0] SEG7_4 = 7'b0011001;
  localparam logic [6:0] SEG7_5 = 7'b0010010;
  localparam logic [6:0] SEG7_6 = 7'b0000010;
  localparam logic [6:0] SEG7_7 = 7'b1111000;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0010000;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b0000011;
  localparam logic [6:0] SEG7_C = 7'b1000110;
  localparam logic [6:0] SEG7_D = 7'b0100001;
  localparam logic [6:0] SEG7_E = 7'b0000110;
  localparam logic [6:0] SEG7_F = 7'b0001110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // all anodes high (display blank)
    ST_COUNT = 2'd1,  // strobe+pattern seen, waiting for it to hold stable
    ST_HOLD  = 2'd2   // captured (or rejected); wait for the next change
  } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
// Combinational decode of an active-low 7-segment pattern back to a hex nibble.
// Patterns outside the 16 legal glyphs decode to nibble 0 with o_err set.
// Ports:
//   i_seg    in  7  segment pattern, active-low, bit0=a .. bit6=g
//   o_nibble out 4  decoded hex value
//   o_err    out 1  pattern is not a legal glyph
// -----------------------------------------------------------------------------
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_nibble = 4'h0;
    o_err    = 1'b0;
    case (i_seg)
      SEG7_0:  o_nibble = 4'h0;
      SEG7_1:  o_nibble = 4'h1;
      SEG7_2:  o_nibble = 4'h2;
      SEG7_3:  o_nibble = 4'h3;
      SEG7_4:  o_nibble = 4'h4;
      SEG7_5:  o_nibble = 4'h5;
      SEG7_6:  o_nibble = 4'h6;
      SEG7_7:  o_nibble = 4'h7;
      SEG7_8:  o_nibble = 4'h8;
      SEG7_9:  o_nibble = 4'h9;
      SEG7_A:  o_nibble = 4'hA;
      SEG7_B:  o_nibble = 4'hB;
      SEG7_C:  o_nibble = 4'hC;
      SEG7_D:  o_nibble = 4'hD;
      SEG7_E:  o_nibble = 4'hE;
      SEG7_F:  o_nibble = 4'hF;
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Receive side of a multiplexed 7-segment display bus. Synchronises the segment
// bus and anode strobes, waits for each strobe+pattern to hold stable for
// STABLE_CYCLES cycles, decodes the digit and publishes a complete multi-digit
// value once every digit of a scan frame has been captured.
// Ports:
//   clk          in   1             clock
//   rst_n        in   1             asynchronous active-low reset
//   seg_in       in   7             segments, active-low, bit0=a .. bit6=g (async)
//   an_in        in   NUM_DIGITS    anode strobes, active-low (async)
//   value_out    out  4*NUM_DIGITS  decoded value, digit i at [4i+3:4i]
//   digit_err    out  NUM_DIGITS    captured pattern was not a legal glyph
//   frame_valid  out  1             one-cycle pulse when value_out/digit_err update
//   sync_err     out  1             one-cycle pulse: stable strobe had >=2 anodes low
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    sync_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers plus a previous-cycle copy for change detection
  // ---------------------------------------------------------------------------
  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0] r_an_s1,  r_an_s2,  r_an_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronisers reset to the inactive (all-high) level so leaving
      // reset never looks like a strobe with every anode low.
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
    end else begin
      // NOTE: non-blocking assignments give every flop the pre-edge value of
      // its source, which is what makes this a real shift chain.
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_an_s1    <= an_in;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
    end
  end

  logic w_changed, w_blank;
  assign w_changed = ({r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev});
  assign w_blank   = &r_an_s2;

  // ---------------------------------------------------------------------------
  // One-hot-to-index encoder with multiple-low detection
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_idx;
  logic             w_any_low, w_multi_low;

  always_comb begin
    w_idx       = '0;
    w_any_low   = 1'b0;
    w_multi_low = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an_s2[i]) begin
        if (w_any_low) w_multi_low = 1'b1;
        w_any_low = 1'b1;
        w_idx     = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph decode of the synchronised segment bus
  // ---------------------------------------------------------------------------
  logic [3:0] w_nibble;
  logic       w_glyph_err;

  seg7_to_hex u_dec (
    .i_seg    (r_seg_s2),
    .o_nibble (w_nibble),
    .o_err    (w_glyph_err)
  );

  // ---------------------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------------------
  scan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stable_hit, w_capture;

  // This edge is the one on which the counter reaches STABLE_CYCLES.
  assign w_stable_hit = (r_state == ST_COUNT) && !w_changed &&
                        (r_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_capture    = w_stable_hit && w_any_low && !w_multi_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_blank) begin
            r_state <= ST_COUNT;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (w_changed) begin
            if (w_blank) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= CNT_W'(1);
            end
          end else if (w_stable_hit) begin
            r_state  <= ST_HOLD;
            r_cnt    <= CNT_W'(STABLE_CYCLES);
            sync_err <= w_multi_low;
          end else if (r_cnt < CNT_W'(STABLE_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_changed) begin
            if (w_blank) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_COUNT;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow capture, frame mask and publish
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_err, r_mask;
  logic                    r_publish;
  logic [NUM_DIGITS-1:0]   w_cap_bit, w_mask_next;

  // A publish clears the mask first, so a capture on the same edge lands in
  // the next frame's mask.
  assign w_cap_bit   = w_capture ? (NUM_DIGITS'(1) << w_idx) : '0;
  assign w_mask_next = (r_publish ? '0 : r_mask) | w_cap_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_err       <= '0;
      r_mask      <= '0;
      r_publish   <= 1'b0;
      value_out   <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      r_mask      <= w_mask_next;
      r_publish   <= w_capture && (&w_mask_next);
      frame_valid <= r_publish;
      if (r_publish) begin
        value_out <= r_shadow;
        digit_err <= r_err;
      end
      if (w_capture) begin
        r_shadow[{w_idx, 2'b00} +: 4] <= w_nibble;
        r_err[w_idx]                  <= w_glyph_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench: directed scan scenarios plus a randomized phase, with a
// behavioural model (input delay queue, run-length of identical samples,
// glyph table lookup, per-digit "seen" flags) compared on every cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [10:0] BLANKV = 11'h7FF;  // {an, seg} with nothing driven

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = 7'h7F;
  logic [ND-1:0] an_in = '1;
  logic [4*ND-1:0] value_out;
  logic [ND-1:0]   digit_err;
  logic            frame_valid, sync_err;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value_out   (value_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] glyph_tab [16];
  initial glyph_tab = '{SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5, SEG7_6, SEG7_7,
                        SEG7_8, SEG7_9, SEG7_A, SEG7_B, SEG7_C, SEG7_D, SEG7_E, SEG7_F};

  function automatic void tb_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
    n = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == s) begin
        n = 4'(i);
        e = 1'b0;
      end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [10:0]     m_dly [$];
  logic [10:0]     m_run_val, m_cur;
  int              m_run_len, m_lows, m_k;
  logic [3:0]      m_shadow [ND];
  logic            m_serr [ND];
  bit              m_seen [ND];
  bit              m_pub, m_pub_now, m_all;
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_derr;
  bit              m_fv, m_se;
  logic [3:0]      m_nib;
  logic            m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dly.delete();
      m_dly.push_back(BLANKV);
      m_dly.push_back(BLANKV);
      m_run_val = BLANKV;
      m_run_len = 0;
      for (int i = 0; i < ND; i++) begin
        m_shadow[i] = 4'h0;
        m_serr[i]   = 1'b0;
        m_seen[i]   = 1'b0;
      end
      m_pub = 0; m_val = '0; m_derr = '0; m_fv = 0; m_se = 0;
    end else begin
      // Logic sees inputs two samples late.
      m_dly.push_back({an_in, seg_in});
      m_cur = m_dly.pop_front();
      if (m_cur == m_run_val) m_run_len++;
      else begin
        m_run_val = m_cur;
        m_run_len = 1;
      end
      m_pub_now = m_pub;
      m_pub = 0; m_fv = 0; m_se = 0;
      if (m_pub_now) begin
        for (int i = 0; i < ND; i++) begin
          m_val[4*i +: 4] = m_shadow[i];
          m_derr[i]       = m_serr[i];
          m_seen[i]       = 0;
        end
        m_fv = 1;
      end
      if (m_run_len == SC && m_cur[10:7] != 4'hF) begin
        m_lows = 0;
        m_k = 0;
        for (int i = 0; i < ND; i++)
          if (!m_cur[7+i]) begin
            m_lows++;
            m_k = i;
          end
        if (m_lows == 1) begin
          tb_decode(m_cur[6:0], m_nib, m_e);
          m_shadow[m_k] = m_nib;
          m_serr[m_k]   = m_e;
          m_seen[m_k]   = 1;
          m_all = 1;
          for (int i = 0; i < ND; i++) if (!m_seen[i]) m_all = 0;
          m_pub = m_all;
        end else begin
          m_se = 1;
        end
      end
    end
  end

  // Per-cycle compare plus pulse counters taken from the DUT.
  int fv_cnt = 0;
  int se_cnt = 0;
  always @(negedge clk) begin
    check("value_out", 32'(value_out), 32'(m_val));
    check("digit_err", 32'(digit_err), 32'(m_derr));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("sync_err", 32'(sync_err), 32'(m_se));
    if (frame_valid) fv_cnt++;
    if (sync_err) se_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    @(negedge clk);
    #1;
    an_in  = an;
    seg_in = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan_digit(input int k, input int nib, input int n);
    logic [ND-1:0] an;
    an = ~(ND'(1) << k);
    drive(an, glyph_tab[nib], n);
  endtask

  task automatic blank(input int n);
    drive('1, 7'h7F, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    // 1: reset with random inputs
    rst_n = 1'b0;
    repeat (10) drive(ND'($urandom), 7'($urandom), 1);
    @(negedge clk);
    check("t1_rst_value", 32'(value_out), 32'h0);
    check("t1_rst_err", 32'(digit_err), 32'h0);
    check("t1_rst_pulses", 32'({frame_valid, sync_err}), 32'h0);
    blank(2);
    #1;
    rst_n = 1'b1;
    base = fv_cnt;
    blank(10);
    check("t1_post_value", 32'(value_out), 32'h0);
    check("t1_post_frames", 32'(fv_cnt - base), 32'd0);

    // 2: clean frame 4321
    base = fv_cnt;
    for (int d = 0; d < ND; d++) scan_digit(d, d + 1, 8);
    blank(6);
    check("t2_frames", 32'(fv_cnt - base), 32'd1);
    check("t2_value", 32'(value_out), 32'h4321);
    check("t2_err", 32'(digit_err), 32'h0);

    // 3: glitch on digit 0 -> frame stays incomplete
    base = fv_cnt;
    scan_digit(0, 5, SC - 1);
    blank(4);
    for (int d = 1; d < ND; d++) scan_digit(d, d + 5, 8);
    blank(6);
    check("t3_frames", 32'(fv_cnt - base), 32'd0);
    check("t3_value_held", 32'(value_out), 32'h4321);

    // 4: illegal glyph on digit 2 of FA0C
    pulse_reset();
    base = fv_cnt;
    scan_digit(0, 12, 8);
    scan_digit(1, 0, 8);
    drive(4'b1011, 7'b1111111, 8);
    scan_digit(3, 15, 8);
    blank(6);
    check("t4_frames", 32'(fv_cnt - base), 32'd1);
    check("t4_value", 32'(value_out), 32'hF00C);
    check("t4_err", 32'(digit_err), 32'b0100);

    // 5: two anodes low -> one sync_err, no mask bits set
    base = se_cnt;
    drive(4'b1100, SEG7_8, 6);
    blank(6);
    check("t5_sync_err", 32'(se_cnt - base), 32'd1);
    base = fv_cnt;
    scan_digit(2, 3, 8);
    scan_digit(3, 3, 8);
    blank(6);
    check("t5_no_frame", 32'(fv_cnt - base), 32'd0);

    // Randomized phase, checked every cycle against the model
    for (int s = 0; s < 300; s++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 9);
      if (kind < 7)       scan_digit($urandom_range(0, ND - 1), $urandom_range(0, 15), len);
      else if (kind == 7) drive(~(ND'(1) << $urandom_range(0, ND - 1)), 7'($urandom), len);
      else if (kind == 8) blank(len);
      else                drive(ND'($urandom), 7'($urandom), len);
    end
    blank(6);

    // 6: reset mid-frame, then BEEF
    scan_digit(0, 1, 8);
    scan_digit(1, 2, 8);
    pulse_reset();
    base = fv_cnt;
    scan_digit(0, 15, 8);
    scan_digit(1, 14, 8);
    scan_digit(2, 14, 8);
    scan_digit(3, 11, 8);
    blank(6);
    check("t6_frames", 32'(fv_cnt - base), 32'd1);
    check("t6_value", 32'(value_out), 32'hBEEF);
    check("t6_err", 32'(digit_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
